// File: rtl/arm_core_defs.sv
// Shared fetch-side definitions for the ARM core:
// reset vector, word geometry, fetch FSM encoding and queue entry layout.
package arm_core_defs;

  localparam logic [31:0] ARM_RESET_VECTOR = 32'h0000_0000;
  localparam int          ARM_INSTR_W      = 32;
  localparam logic [31:0] ARM_PC_INC       = 32'd4;

  localparam int ENTRY_INSTR_W = ARM_INSTR_W;
  localparam int ENTRY_PC_W    = 32;
  localparam int ENTRY_ABORT_W = 1;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ENTRY_INSTR_W-1:0] instr;
    logic [ENTRY_PC_W-1:0]    pc;
    logic [ENTRY_ABORT_W-1:0] abort;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small circular buffer for fetched words: synchronous clear,
// push/pop, occupancy count and head exposed straight from storage.
module prefetch_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // DEPTH need not be a power of two, so wrap explicitly
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arm_prefetch_queue.sv
// ARM fetch stage: word fetch FSM feeding a prefetch queue into decode.
// Define ARM_THUMB_EN to add the thumb_state input and halfword fetch.
module arm_prefetch_queue
  import arm_core_defs::*;
#(
  parameter int          DEPTH        = 3,
  parameter logic [31:0] RESET_VECTOR = ARM_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_abort,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
`ifdef ARM_THUMB_EN
  input  logic        thumb_state,
`endif
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [27:0] instr,
  output logic [3:0]  instr_cond,
  output logic [31:0] instr_pc,
  output logic        instr_abort
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_inc;
  logic [31:0]   target;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  assign mem_req     = (state == FETCH_REQ);
  assign instr_valid = (count != '0);

  // a redirect voids both the returning word and any decode handshake
  assign push = mem_req && mem_ack && !branch_valid;
  assign pop  = instr_valid && instr_ready && !branch_valid;

  assign count_nxt = count + CW'(push) - CW'(pop);

  assign wr_entry.instr = mem_rdata;
  assign wr_entry.pc    = fetch_pc;
  assign wr_entry.abort = mem_abort;

  assign instr_pc    = head.pc;
  assign instr_abort = head.abort;

`ifdef ARM_THUMB_EN
  logic        thumb;
  logic [15:0] half;

  assign pc_inc     = thumb ? 32'd2 : ARM_PC_INC;
  assign target     = branch_target & (thumb_state ? ~32'h1 : ~32'h3);
  assign mem_addr   = fetch_pc & ~32'h3;
  assign half       = instr_pc[1] ? head.instr[31:16] : head.instr[15:0];
  assign instr      = {12'h000, half};
  assign instr_cond = 4'h0;

  always_ff @(posedge clk) begin
    if (rst)               thumb <= 1'b0;
    else if (branch_valid) thumb <= thumb_state;
  end
`else
  assign pc_inc     = ARM_PC_INC;
  assign target     = branch_target & ~32'h3;
  assign mem_addr   = fetch_pc;
  assign instr      = head.instr[27:0];
  assign instr_cond = head.instr[31:28];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH_IDLE;
      fetch_pc <= RESET_VECTOR;
    end else if (branch_valid) begin
      state    <= FETCH_IDLE;
      fetch_pc <= target;
    end else begin
      unique case (state)
        FETCH_IDLE: begin
          if (count_nxt < FULL) state <= FETCH_REQ;
        end
        FETCH_REQ: begin
          if (mem_ack) begin
            fetch_pc <= fetch_pc + pc_inc;
            if (count_nxt >= FULL) state <= FETCH_IDLE;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  prefetch_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (branch_valid),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_arm_prefetch_queue.sv
// Bench for arm_prefetch_queue: randomized memory/decode/branch traffic
// checked against a queue-based model of the fetch stream.
module tb_arm_prefetch_queue;

  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_abort = 1'b0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [27:0] instr;
  logic [3:0]  instr_cond;
  logic [31:0] instr_pc;
  logic        instr_abort;
`ifdef ARM_THUMB_EN
  logic        thumb_state = 1'b0;
`endif

  arm_prefetch_queue #(
    .DEPTH        (DEPTH),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .mem_abort     (mem_abort),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
`ifdef ARM_THUMB_EN
    .thumb_state   (thumb_state),
`endif
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_cond    (instr_cond),
    .instr_pc      (instr_pc),
    .instr_abort   (instr_abort)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [32:0] q[$];
  logic [31:0] exp_pc   = '0;
  logic [31:0] m_fetch  = '0;
  logic [31:0] first_pc = '0;
  logic [31:0] br_tgt   = '0;
  int idle_run = 0;
  int pops     = 0;
  int acks     = 0;
  int rdy_mode = 1;
  int max_wait = 0;
  int br_rate  = 0;
  int wcnt     = 0;
  bit fix_wait = 1'b1;
  bit scr      = 1'b0;
  bit rst_set  = 1'b1;
  bit br_force = 1'b0;
  bit prev_rst = 1'b1;
  bit busy     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a, input bit s);
    return s ? ({a[15:0], a[31:16]} ^ 32'hC3A5_96E1) : a;
  endfunction

  task automatic drive();
    rst = rst_set;
    if (!mem_req) busy = 1'b0;
    else if (!busy) begin
      busy = 1'b1;
      wcnt = fix_wait ? max_wait : int'($urandom_range(0, max_wait));
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
    mem_abort = 1'b0;
    if (mem_req && busy) begin
      if (wcnt == 0) begin
        mem_ack   = 1'b1;
        busy      = 1'b0;
        mem_rdata = word_of(mem_addr, scr);
        mem_abort = (mem_addr[7:0] == 8'h20);
      end else wcnt--;
    end
    case (rdy_mode)
      1:       instr_ready = 1'b1;
      2:       instr_ready = 1'b0;
      default: instr_ready = ($urandom_range(0, 3) != 0);
    endcase
    branch_valid  = 1'b0;
    branch_target = $urandom;
    if (br_force) begin
      branch_valid  = 1'b1;
      branch_target = br_tgt;
    end else if (br_rate > 0 && $urandom_range(0, br_rate - 1) == 0) begin
      branch_valid = 1'b1;
      if ($urandom_range(0, 3) == 0)
        branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    end
  endtask

  task automatic evaluate();
    logic [32:0] e;
    if (rst) begin
      q.delete();
      m_fetch  = 32'h0;
      exp_pc   = 32'h0;
      idle_run = 0;
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        check("rst_req",   32'(mem_req), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_pc",    instr_pc, 32'h0);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_cond",  32'(instr_cond), 32'h0);
        check("rst_abort", 32'(instr_abort), 32'h0);
        prev_rst = 1'b0;
      end
      check("valid", 32'(instr_valid), 32'(q.size() != 0));
      if (mem_req) begin
        check("addr", mem_addr, m_fetch);
        check("req_room", 32'(q.size() < DEPTH), 32'h1);
      end
      if (!mem_req && q.size() < DEPTH && !branch_valid) idle_run++;
      else idle_run = 0;
      check("stall", 32'(idle_run > 1), 32'h0);
      if (instr_valid && instr_ready && !branch_valid && q.size() != 0) begin
        e = q.pop_front();
        check("pc", instr_pc, exp_pc);
        check("abort", 32'(instr_abort), 32'(e[32]));
        if (!e[32]) begin
          check("instr", 32'(instr), 32'(e[27:0]));
          check("cond", 32'(instr_cond), 32'(e[31:28]));
        end
        if (pops == 0) first_pc = instr_pc;
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (mem_req && mem_ack && !branch_valid) begin
        q.push_back({mem_abort, mem_rdata});
        m_fetch = m_fetch + 32'd4;
        acks++;
      end
      if (branch_valid) begin
        q.delete();
        m_fetch = branch_target & ~32'h3;
        exp_pc  = m_fetch;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    evaluate();
  endtask

  task automatic do_reset();
    rst_set = 1'b1;
    cycle();
    rst_set = 1'b0;
    cycle();
  endtask

  initial begin
    // zero-wait memory echoing the address, decode always ready
    rst_set = 1'b1;
    cycle();
    do_reset();
    rdy_mode = 1; max_wait = 0; fix_wait = 1'b1; scr = 1'b0; pops = 0;
    repeat (20) cycle();
    check("thruput", 32'(pops), 32'd19);

    // decode stalled: queue fills with 0,4,8 then fetch stops
    rdy_mode = 2;
    do_reset();
    acks = 0;
    repeat (10) cycle();
    check("fill_acks", 32'(acks), 32'd3);
    check("full_req", 32'(mem_req), 32'h0);
    check("full_valid", 32'(instr_valid), 32'h1);
    rdy_mode = 1; pops = 0;
    repeat (8) cycle();
    check("resume_pops", 32'(pops), 32'd8);

    // two wait states per fetch
    scr = 1'b1; max_wait = 2; acks = 0;
    repeat (30) cycle();
    check("wait_acks", 32'(acks), 32'd10);

    // redirect with two queued entries and an ack in flight
    rdy_mode = 2; max_wait = 0;
    do_reset();
    for (int i = 0; i < 10 && q.size() != 2; i++) cycle();
    check("br_setup", 32'(q.size()), 32'd2);
    br_force = 1'b1; br_tgt = 32'h0000_0103;
    cycle();
    br_force = 1'b0;
    check("br_inflight", 32'(mem_req && mem_ack), 32'h1);
    rdy_mode = 1;
    cycle();
    check("br_empty", 32'(instr_valid), 32'h0);
    pops = 0;
    for (int i = 0; i < 10 && pops == 0; i++) cycle();
    check("br_first_pc", first_pc, 32'h0000_0100);

    // random traffic with branches, wait states and address wrap
    fix_wait = 1'b0; max_wait = 2; rdy_mode = 0; br_rate = 25;
    repeat (3000) cycle();
    br_rate = 0;

    // reset while a fetch is outstanding and two entries are queued
    rdy_mode = 2; fix_wait = 1'b1; max_wait = 3;
    do_reset();
    for (int i = 0; i < 40 && q.size() != 2; i++) cycle();
    check("rst_setup", 32'(q.size()), 32'd2);
    rst_set = 1'b1;
    cycle();
    rst_set = 1'b0;
    cycle();
    rdy_mode = 1; max_wait = 0; pops = 0;
    for (int i = 0; i < 10 && pops == 0; i++) cycle();
    check("rst_first_pc", first_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arm_prefetch_queue.md
Name: arm_prefetch_queue

Overview:
Instruction fetch stage directly upstream of the decode/register-addressing logic.
- Issues word fetches to instruction memory and buffers the returned words in a small FIFO.
- Presents each instruction with its fetch PC and abort flag to decode through a valid/ready handshake.
- On a branch redirect from execute, discards buffered and in-flight fetches and restarts at the target.

Parameters:
DEPTH, 3, number of buffered instruction entries, minimum 2; models the ARM7 fetch/decode/execute slots.
RESET_VECTOR, 32'h0000_0000, first fetch address after reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
mem_req  output  1  fetch request, held until mem_ack
mem_addr  output  32  fetch address, word aligned, stable while mem_req=1
mem_ack  input  1  fetch completes this cycle; mem_rdata/mem_abort valid
mem_rdata  input  32  fetched word
mem_abort  input  1  prefetch abort for this fetch
branch_valid  input  1  redirect pulse from execute
branch_target  input  32  redirect address
instr_valid  output  1  queue head valid
instr_ready  input  1  decode accepts head
instr  output  28  instruction bits [27:0]; decode uses only these
instr_cond  output  4  instruction bits [31:28]
instr_pc  output  32  address of head instruction
instr_abort  output  1  head fetch aborted; instr/instr_cond are don't-care

Behaviour:
- Reset, evaluated on the clock edge:
  - fetch_pc=RESET_VECTOR, count=0, mem_req=0, instr_valid=0.
  - instr, instr_cond, instr_pc and instr_abort reset to 0.
- First mem_req is asserted in the cycle after rst deasserts.
- FSM states:
  - IDLE: mem_req=0. Go to REQ when count<DEPTH and no branch_valid.
  - REQ: mem_req=1, mem_addr=fetch_pc.
    - mem_ack=1: push {mem_rdata, fetch_pc, mem_abort}, fetch_pc+=4. Stay in REQ if count after this cycle is <DEPTH, else go to IDLE.
    - mem_ack=0: hold the request.
- Memory may take any number of wait cycles; the ack cycle carries the data. Minimum fetch latency is 1 cycle, so the throughput is one word per cycle.
- Decode handshake:
  - Pop when instr_valid && instr_ready.
  - Outputs show the FIFO head combinationally from registered storage.
  - instr_valid = (count!=0).
  - Push and pop in the same cycle leave count unchanged.
- Full: no request is issued while count==DEPTH. If a pop happens in a full cycle, the request is issued the next cycle.
- Empty: instr_valid=0; instr_ready is ignored.
- Branch, highest priority:
  - branch_valid=1 in a cycle: FIFO is cleared (count=0) and a simultaneous pop is void.
  - An ack in the same cycle is discarded, with no push.
  - fetch_pc=branch_target & ~32'h3, state=IDLE, mem_req=0 for that cycle.
  - Next cycle: REQ to the target.
  - Consecutive branch_valid cycles: the last target wins.
- Abort: the entry is stored with instr_abort=1. Fetching continues sequentially; execute decides whether to take the abort.
- fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- Reset mid-fetch: an outstanding request is abandoned. Memory must tolerate mem_req dropping before mem_ack.

Optional Feature:
ARM_THUMB_EN
- Defined:
  - Adds input thumb_state (1 bit, sampled with branch_valid and held by execute).
  - In Thumb state fetch_pc increments by 2. mem_addr = fetch_pc & ~3.
  - instr = 16-bit halfword selected by instr_pc[1], zero-extended into [27:0]; instr_cond=0.
  - branch_target is aligned with & ~1.
- Undefined: port absent, ARM-only behaviour as above.

Decomposition:
- Shared package/header arm_core_defs:
  - ARM_RESET_VECTOR, ARM_INSTR_W=32, ARM_PC_INC=4.
  - Fetch FSM state encodings FETCH_IDLE/FETCH_REQ.
  - Entry field widths (instr 32, pc 32, abort 1).
- One sub-module: prefetch_fifo
  - Parameterised width/depth.
  - Synchronous clear, push/pop, count, head outputs.
  - Fetch FSM and PC logic stay in the top.

Test Plan:
1. Reset release, zero-wait memory returning addr as data, instr_ready=1 -> instr_pc 0,4,8,... one per cycle from cycle 2; instr[27:0]=instr_pc[27:0].
2. instr_ready=0 for 10 cycles -> exactly 3 fetches (0,4,8), mem_req low once full. Then ready=1 -> pops 0,4,8 and fetching resumes at 12 in the pop cycle's next cycle.
3. Memory with 2 wait states -> mem_addr stable across wait cycles; each entry pushed only on the ack cycle.
4. branch_valid with target 32'h0000_0103 while 2 entries are queued and ack is in flight -> queue empty next cycle, acked word dropped, next mem_addr=32'h100, first instr_pc after the redirect=32'h100.
5. mem_abort=1 on fetch of 32'h20 -> entry at pc 32'h20 has instr_abort=1, neighbours 0; fetch of 32'h24 proceeds.
6. rst asserted while mem_req=1 and count=2 -> next cycle instr_valid=0, mem_req=0; fetch restarts at RESET_VECTOR.
